// File: rtl/prga_decrypt_fsm.sv
// prga_decrypt_fsm: RC4 pseudo-random generation stage.
// Once the key schedule hands over the S memory (start high), this block walks the
// RC4 PRGA over the permuted S array. Each keystream byte is XORed with one byte of
// the encrypted ROM, and the plaintext goes to the decrypted-message RAM.
// Each message byte takes nine states. S memory and ROM have one cycle of read
// latency: the address is driven in an ADDR state and the data is taken in the
// following LATCH state.
module prga_decrypt_fsm #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned K_W     = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [7:0]     s_q,
    output logic [7:0]     s_address,
    output logic [7:0]     s_data,
    output logic           s_wren,
    output logic           s_rden,
    output logic [K_W-1:0] rom_address,
    input  logic [7:0]     rom_q,
    output logic [K_W-1:0] ram_address,
    output logic [7:0]     ram_data,
    output logic           ram_wren,
    output logic           busy,
    output logic           done
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StAddrI  = 4'd1,
        StLatchI = 4'd2,
        StAddrJ  = 4'd3,
        StLatchJ = 4'd4,
        StWrI    = 4'd5,
        StWrJ    = 4'd6,
        StAddrF  = 4'd7,
        StLatchF = 4'd8,
        StWrOut  = 4'd9,
        StDone   = 4'd10
    } state_e;

    // Index of the final message byte; reaching it in WR_OUT ends the run.
    localparam logic [K_W-1:0] LastK = K_W'(MSG_LEN - 1);

    state_e         state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [K_W-1:0] k_q, k_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [7:0]     f_q, f_d;
    logic [7:0]     rom_byte_q, rom_byte_d;

    // State and datapath registers; a low reset forces IDLE and zeroes every index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            k_q        <= '0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            f_q        <= 8'd0;
            rom_byte_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            f_q        <= f_d;
            rom_byte_q <= rom_byte_d;
        end
    end

    // Next-state and datapath updates; all S-index arithmetic wraps modulo 256.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        si_d       = si_q;
        sj_d       = sj_q;
        f_d        = f_q;
        rom_byte_d = rom_byte_q;
        case (state_q)
            StIdle: begin
                // start is only looked at here; later drops are ignored.
                if (start) begin
                    i_d     = i_q + 8'd1;
                    state_d = StAddrI;
                end
            end
            StAddrI: state_d = StLatchI;
            StLatchI: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = StAddrJ;
            end
            StAddrJ: state_d = StLatchJ;
            StLatchJ: begin
                sj_d    = s_q;
                state_d = StWrI;
            end
            StWrI: state_d = StWrJ;
            StWrJ: state_d = StAddrF;
            StAddrF: state_d = StLatchF;
            StLatchF: begin
                f_d        = s_q;
                rom_byte_d = rom_q;
                state_d    = StWrOut;
            end
            StWrOut: begin
                if (k_q == LastK) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + K_W'(1);
                    i_d     = i_q + 8'd1;
                    state_d = StAddrI;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Moore output decode from the state and the datapath registers.
    always_comb begin
        s_address   = 8'd0;
        s_data      = 8'd0;
        s_wren      = 1'b0;
        s_rden      = 1'b0;
        ram_data    = 8'd0;
        ram_wren    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        rom_address = k_q;
        ram_address = k_q;
        case (state_q)
            StIdle: busy = 1'b0;
            StAddrI: begin
                s_address = i_q;
                s_rden    = 1'b1;
            end
            StAddrJ: begin
                s_address = j_q;
                s_rden    = 1'b1;
            end
            StWrI: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
            end
            StWrJ: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
            end
            StAddrF: begin
                // Pre-swap si+sj equals post-swap S[i]+S[j].
                s_address = si_q + sj_q;
                s_rden    = 1'b1;
            end
            StWrOut: begin
                ram_data = f_q ^ rom_byte_q;
                ram_wren = 1'b1;
            end
            StDone: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm. DUT A runs a 32-byte message and DUT B runs 256 bytes.
// The 256-byte instance lets i wrap from 255 to 0. Expected values come from a plain
// software RC4 model: KSA followed by PRGA on byte arrays.
`timescale 1ns/1ps
module tb_prga_decrypt_fsm;
    localparam int NA = 32;
    localparam int NB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       a_reset, a_start, a_s_wren, a_s_rden, a_ram_wren, a_busy, a_done, a_load;
    logic [7:0] a_s_q, a_s_address, a_s_data, a_rom_address, a_rom_q;
    logic [7:0] a_ram_address, a_ram_data, a_s_ra_q, a_rom_ra_q;
    logic [7:0] a_s_mem [256];
    logic [7:0] a_ram   [256];
    logic [7:0] a_rom   [256];

    logic       b_reset, b_start, b_s_wren, b_s_rden, b_ram_wren, b_busy, b_done, b_load;
    logic [7:0] b_s_q, b_s_address, b_s_data, b_rom_address, b_rom_q;
    logic [7:0] b_ram_address, b_ram_data, b_s_ra_q, b_rom_ra_q;
    logic [7:0] b_s_mem [256];
    logic [7:0] b_ram   [256];
    logic [7:0] b_rom   [256];

    logic [7:0] s_img [256];
    logic [7:0] m_s   [256];
    logic [7:0] m_ks  [256];
    logic [7:0] key   [16];
    int         key_len;

    prga_decrypt_fsm #(.MSG_LEN(NA), .K_W(8)) u_dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .s_q(a_s_q),
        .s_address(a_s_address), .s_data(a_s_data), .s_wren(a_s_wren), .s_rden(a_s_rden),
        .rom_address(a_rom_address), .rom_q(a_rom_q), .ram_address(a_ram_address),
        .ram_data(a_ram_data), .ram_wren(a_ram_wren), .busy(a_busy), .done(a_done)
    );

    prga_decrypt_fsm #(.MSG_LEN(NB), .K_W(8)) u_dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .s_q(b_s_q),
        .s_address(b_s_address), .s_data(b_s_data), .s_wren(b_s_wren), .s_rden(b_s_rden),
        .rom_address(b_rom_address), .rom_q(b_rom_q), .ram_address(b_ram_address),
        .ram_data(b_ram_data), .ram_wren(b_ram_wren), .busy(b_busy), .done(b_done)
    );

    // Memory models: registered address, data readable in the following cycle.
    always @(posedge clk) begin
        a_s_ra_q   <= a_s_address;
        a_rom_ra_q <= a_rom_address;
        if (a_load) begin
            for (int n = 0; n < 256; n++) begin
                a_s_mem[n] <= s_img[n];
                a_ram[n]   <= 8'hEE;
            end
        end else begin
            if (a_s_wren) a_s_mem[a_s_address] <= a_s_data;
            if (a_ram_wren) a_ram[a_ram_address] <= a_ram_data;
        end
    end
    assign a_s_q   = a_s_mem[a_s_ra_q];
    assign a_rom_q = a_rom[a_rom_ra_q];

    always @(posedge clk) begin
        b_s_ra_q   <= b_s_address;
        b_rom_ra_q <= b_rom_address;
        if (b_load) begin
            for (int n = 0; n < 256; n++) begin
                b_s_mem[n] <= s_img[n];
                b_ram[n]   <= 8'hEE;
            end
        end else begin
            if (b_s_wren) b_s_mem[b_s_address] <= b_s_data;
            if (b_ram_wren) b_ram[b_ram_address] <= b_ram_data;
        end
    end
    assign b_s_q   = b_s_mem[b_s_ra_q];
    assign b_rom_q = b_rom[b_rom_ra_q];

    // Per-cycle protocol watch on both instances.
    always @(negedge clk) begin
        checks++;
        if ((a_s_wren === 1'b1 && (a_ram_wren === 1'b1 || a_s_rden === 1'b1)) ||
            (b_s_wren === 1'b1 && (b_ram_wren === 1'b1 || b_s_rden === 1'b1)) ||
            (a_done === 1'b1 && (a_busy !== 1'b0 || a_s_wren !== 1'b0 || a_ram_wren !== 1'b0)) ||
            (b_done === 1'b1 && (b_busy !== 1'b0 || b_s_wren !== 1'b0 || b_ram_wren !== 1'b0)))
        begin
            failures++;
            $display("FAIL protocol t=%0t a: swr=%b srd=%b rwr=%b busy=%b done=%b b: swr=%b srd=%b rwr=%b busy=%b done=%b required exclusive enables, idle in done",
                     $time, a_s_wren, a_s_rden, a_ram_wren, a_busy, a_done,
                     b_s_wren, b_s_rden, b_ram_wren, b_busy, b_done);
        end
    end

    task automatic model_identity();
        for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    endtask

    task automatic model_ksa();
        int jj = 0;
        logic [7:0] t;
        model_identity();
        for (int n = 0; n < 256; n++) begin
            jj = (jj + int'(m_s[n]) + int'(key[n % key_len])) % 256;
            t = m_s[n]; m_s[n] = m_s[jj]; m_s[jj] = t;
        end
    endtask

    // Textbook RC4 PRGA from i=j=0; leaves the final S in m_s and keystream in m_ks.
    task automatic model_prga(input int nbytes);
        int ii = 0;
        int jj = 0;
        logic [7:0] t;
        for (int b = 0; b < nbytes; b++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(m_s[ii])) % 256;
            t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
            m_ks[b] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256];
        end
    endtask

    task automatic random_key();
        key_len = $urandom_range(1, 16);
        for (int n = 0; n < 16; n++) key[n] = 8'($urandom);
    endtask

    // Hold reset, load S from m_s and clear RAM to EE, then release.
    task automatic prep_a();
        a_start = 1'b0;
        a_reset = 1'b0;
        for (int n = 0; n < 256; n++) s_img[n] = m_s[n];
        a_load = 1'b1;
        @(posedge clk); #1;
        a_load  = 1'b0;
        a_reset = 1'b1;
    endtask

    task automatic prep_b();
        b_start = 1'b0;
        b_reset = 1'b0;
        for (int n = 0; n < 256; n++) s_img[n] = m_s[n];
        b_load = 1'b1;
        @(posedge clk); #1;
        b_load  = 1'b0;
        b_reset = 1'b1;
    endtask

    // Raise start and count rising edges (including the sampling one) until done.
    task automatic run_a(input bit toggle, output int edges);
        a_start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (toggle) a_start = 1'($urandom_range(0, 1));
        end while (a_done !== 1'b1 && edges < 9 * NA + 20);
        a_start = 1'b0;
    endtask

    task automatic run_b(output int edges);
        b_start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            b_start = 1'($urandom_range(0, 1));
        end while (b_done !== 1'b1 && edges < 9 * NB + 20);
        b_start = 1'b0;
    endtask

    task automatic test_reset();
        model_identity();
        prep_a();
        prep_b();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_s_address, a_s_data, a_s_wren, a_s_rden, a_rom_address, a_ram_address,
             a_ram_data, a_ram_wren, a_busy, a_done} !== '0) begin
            failures++;
            $display("FAIL reset_a outputs got sa=%h sd=%h swr=%b srd=%b rom=%h ra=%h rd=%h rwr=%b busy=%b done=%b required all 0",
                     a_s_address, a_s_data, a_s_wren, a_s_rden, a_rom_address, a_ram_address,
                     a_ram_data, a_ram_wren, a_busy, a_done);
        end
        checks++;
        if ({b_s_address, b_s_data, b_s_wren, b_s_rden, b_rom_address, b_ram_address,
             b_ram_data, b_ram_wren, b_busy, b_done} !== '0) begin
            failures++;
            $display("FAIL reset_b outputs got busy=%b done=%b sa=%h required all 0",
                     b_busy, b_done, b_s_address);
        end
    endtask

    task automatic test_identity();
        logic [7:0] exp3 [3];
        int edges;
        exp3[0] = 8'h02; exp3[1] = 8'h05; exp3[2] = 8'h07;
        for (int n = 0; n < 256; n++) a_rom[n] = 8'h00;
        model_identity();
        prep_a();
        model_prga(NA);
        run_a(1'b0, edges);
        checks++;
        if (edges !== 9 * NA + 1) begin
            failures++;
            $display("FAIL identity_latency got %0d edges required %0d", edges, 9 * NA + 1);
        end
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (a_ram[n] !== exp3[n]) begin
                failures++;
                $display("FAIL identity_ram[%0d] got %h required %h", n, a_ram[n], exp3[n]);
            end
        end
        for (int n = 0; n < NA; n++) begin
            checks++;
            if (a_ram[n] !== (m_ks[n] ^ a_rom[n])) begin
                failures++;
                $display("FAIL identity_model_ram[%0d] got %h required %h", n, a_ram[n],
                         m_ks[n] ^ a_rom[n]);
            end
        end
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (a_s_mem[n] !== m_s[n]) begin
                failures++;
                $display("FAIL identity_s[%0d] got %h required %h", n, a_s_mem[n], m_s[n]);
            end
        end
        checks++;
        if (a_ram_address !== 8'(NA - 1) || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL identity_final k got %h busy %b required %h busy 0", a_ram_address,
                     a_busy, 8'(NA - 1));
        end
    endtask

    task automatic test_rom_pattern();
        logic [7:0] exp3 [3];
        int edges;
        exp3[0] = 8'h43; exp3[1] = 8'h47; exp3[2] = 8'h44;
        a_rom[0] = 8'h41; a_rom[1] = 8'h42; a_rom[2] = 8'h43;
        for (int n = 3; n < 256; n++) a_rom[n] = 8'($urandom);
        model_identity();
        prep_a();
        model_prga(NA);
        run_a(1'b1, edges);
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (a_ram[n] !== exp3[n]) begin
                failures++;
                $display("FAIL rom_pattern_ram[%0d] got %h required %h", n, a_ram[n], exp3[n]);
            end
        end
        for (int n = 0; n < NA; n++) begin
            checks++;
            if (a_ram[n] !== (m_ks[n] ^ a_rom[n])) begin
                failures++;
                $display("FAIL rom_pattern_model_ram[%0d] got %h required %h", n, a_ram[n],
                         m_ks[n] ^ a_rom[n]);
            end
        end
    endtask

    task automatic test_real_key();
        logic [7:0] ct [9];
        logic [7:0] pt [9];
        int edges;
        ct[0] = 8'hBB; ct[1] = 8'hF3; ct[2] = 8'h16; ct[3] = 8'hE8; ct[4] = 8'hD9;
        ct[5] = 8'h40; ct[6] = 8'hAF; ct[7] = 8'h0A; ct[8] = 8'hD3;
        pt[0] = 8'h50; pt[1] = 8'h6C; pt[2] = 8'h61; pt[3] = 8'h69; pt[4] = 8'h6E;
        pt[5] = 8'h74; pt[6] = 8'h65; pt[7] = 8'h78; pt[8] = 8'h74;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79; key_len = 3;
        for (int n = 0; n < 9; n++) a_rom[n] = ct[n];
        for (int n = 9; n < 256; n++) a_rom[n] = 8'($urandom);
        model_ksa();
        prep_a();
        model_prga(NA);
        run_a(1'b1, edges);
        checks++;
        if (edges !== 9 * NA + 1) begin
            failures++;
            $display("FAIL real_key_latency got %0d edges required %0d", edges, 9 * NA + 1);
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (a_ram[n] !== pt[n]) begin
                failures++;
                $display("FAIL real_key_plaintext[%0d] got %h required %h", n, a_ram[n], pt[n]);
            end
        end
        for (int n = 0; n < NA; n++) begin
            checks++;
            if (a_ram[n] !== (m_ks[n] ^ a_rom[n])) begin
                failures++;
                $display("FAIL real_key_model_ram[%0d] got %h required %h", n, a_ram[n],
                         m_ks[n] ^ a_rom[n]);
            end
        end
    endtask

    task automatic test_random();
        int edges;
        for (int it = 0; it < 3; it++) begin
            random_key();
            for (int n = 0; n < 256; n++) a_rom[n] = 8'($urandom);
            model_ksa();
            prep_a();
            model_prga(NA);
            run_a(1'b1, edges);
            for (int n = 0; n < NA; n++) begin
                checks++;
                if (a_ram[n] !== (m_ks[n] ^ a_rom[n])) begin
                    failures++;
                    $display("FAIL random%0d_ram[%0d] got %h required %h", it, n, a_ram[n],
                             m_ks[n] ^ a_rom[n]);
                end
            end
            for (int n = 0; n < 256; n++) begin
                checks++;
                if (a_s_mem[n] !== m_s[n]) begin
                    failures++;
                    $display("FAIL random%0d_s[%0d] got %h required %h", it, n, a_s_mem[n],
                             m_s[n]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        int jj;
        logic [7:0] t;
        random_key();
        for (int n = 0; n < 256; n++) a_rom[n] = 8'($urandom);
        model_ksa();
        prep_a();
        jj = int'(m_s[1]);
        a_start = 1'b1;
        // Six edges from the sampling edge lands in WR_J of byte 1.
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (a_s_wren !== 1'b1 || a_s_address !== 8'(jj) || a_s_data !== m_s[1]) begin
            failures++;
            $display("FAIL midrun_wrj got wr=%b addr=%h data=%h required 1 %h %h", a_s_wren,
                     a_s_address, a_s_data, 8'(jj), m_s[1]);
        end
        a_start = 1'b0;
        a_reset = 1'b0;
        @(posedge clk); #1;
        a_reset = 1'b1;
        checks++;
        if ({a_s_address, a_s_data, a_s_wren, a_s_rden, a_rom_address, a_ram_address,
             a_ram_data, a_ram_wren, a_busy, a_done} !== '0) begin
            failures++;
            $display("FAIL midrun_reset_outputs got sa=%h swr=%b srd=%b busy=%b rwr=%b required all 0",
                     a_s_address, a_s_wren, a_s_rden, a_busy, a_ram_wren);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (a_s_wren !== 1'b0 || a_ram_wren !== 1'b0 || a_busy !== 1'b0) begin
                failures++;
                $display("FAIL midrun_quiet cycle %0d got swr=%b rwr=%b busy=%b required 0 0 0",
                         c, a_s_wren, a_ram_wren, a_busy);
            end
        end
        // The aborted byte completed both swap writes; no RAM byte was written.
        t = m_s[1]; m_s[1] = m_s[jj]; m_s[jj] = t;
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (a_s_mem[n] !== m_s[n] || a_ram[n] !== 8'hEE) begin
                failures++;
                $display("FAIL midrun_mem[%0d] got s=%h ram=%h required s=%h ram=ee", n,
                         a_s_mem[n], a_ram[n], m_s[n]);
            end
        end
        model_prga(NA);
        run_a(1'b1, edges);
        checks++;
        if (edges !== 9 * NA + 1) begin
            failures++;
            $display("FAIL midrun_restart_latency got %0d required %0d", edges, 9 * NA + 1);
        end
        for (int n = 0; n < NA; n++) begin
            checks++;
            if (a_ram[n] !== (m_ks[n] ^ a_rom[n])) begin
                failures++;
                $display("FAIL midrun_restart_ram[%0d] got %h required %h", n, a_ram[n],
                         m_ks[n] ^ a_rom[n]);
            end
        end
    endtask

    task automatic test_done_hold();
        for (int c = 0; c < 50; c++) begin
            a_start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (a_done !== 1'b1 || a_busy !== 1'b0 || a_s_wren !== 1'b0 ||
                a_ram_wren !== 1'b0 || a_s_rden !== 1'b0) begin
                failures++;
                $display("FAIL done_hold cycle %0d got done=%b busy=%b swr=%b rwr=%b srd=%b required 1 0 0 0 0",
                         c, a_done, a_busy, a_s_wren, a_ram_wren, a_s_rden);
            end
        end
        a_start = 1'b0;
    endtask

    task automatic test_wrap();
        int edges;
        int seen [256];
        for (int n = 0; n < 256; n++) b_rom[n] = 8'($urandom);
        model_identity();
        prep_b();
        model_prga(NB);
        run_b(edges);
        checks++;
        if (edges !== 9 * NB + 1 || b_done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_latency got %0d edges done=%b required %0d done=1", edges,
                     b_done, 9 * NB + 1);
        end
        checks++;
        if (b_ram_address !== 8'hFF) begin
            failures++;
            $display("FAIL wrap_final_k got %h required ff", b_ram_address);
        end
        for (int n = 0; n < NB; n++) begin
            checks++;
            if (b_ram[n] !== (m_ks[n] ^ b_rom[n])) begin
                failures++;
                $display("FAIL wrap_ram[%0d] got %h required %h", n, b_ram[n],
                         m_ks[n] ^ b_rom[n]);
            end
        end
        for (int n = 0; n < 256; n++) seen[n] = 0;
        for (int n = 0; n < 256; n++) begin
            if (!$isunknown(b_s_mem[n])) seen[int'(b_s_mem[n])]++;
            checks++;
            if (b_s_mem[n] !== m_s[n]) begin
                failures++;
                $display("FAIL wrap_s[%0d] got %h required %h", n, b_s_mem[n], m_s[n]);
            end
        end
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (seen[n] !== 1) begin
                failures++;
                $display("FAIL wrap_permutation value %h occurs %0d times required 1", n,
                         seen[n]);
            end
        end
    endtask

    initial begin
        a_reset = 1'b0; a_start = 1'b0; a_load = 1'b0;
        b_reset = 1'b0; b_start = 1'b0; b_load = 1'b0;
        key_len = 1;
        for (int n = 0; n < 256; n++) begin
            a_rom[n] = 8'h00;
            b_rom[n] = 8'h00;
        end
        test_reset();
        test_identity();
        test_rom_pattern();
        test_real_key();
        test_random();
        test_reset_mid_run();
        test_done_hold();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
